// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int CNT_W        = $clog2(XLEN_DEFAULT);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: abs() of operands, sign fix of results.
// Latency: combinational.
// Backpressure: none.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: shift-add multiply / restoring divide, one bit per cycle.
// Latency: accept cycle + XLEN CALC cycles, done in cycle XLEN+1 (special cases in
// cycle 1 when MULDIV_FAST_EN is defined). Backpressure: stall held while busy; flush aborts.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            ready,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mag_q, mag_d;
    logic [XLEN-1:0] spv_q, spv_d, result_q, result_d;
    logic            negq_q, negq_d, negr_q, negr_d, spec_q, spec_d;

    logic            sgn_a, sgn_b, sa, sb, b_zero, a_zero, ovf, spec_c;
    logic [XLEN-1:0] abs_a, abs_b, spec_val_c;
    logic [XLEN:0]   mul_sum, div_sh;
    logic            div_ge;
    logic [XLEN-1:0] it_hi, it_lo, res_calc;
    logic [2*XLEN-1:0] raw_res, fix_res;
    logic            res_neg;

    // Operand conditioning and special-case detection on the request inputs
    always_comb begin
        sgn_a  = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
        sgn_b  = sgn_a && (funct3 != F3_MULHSU);
        sa     = sgn_a & op_a[XLEN-1];
        sb     = sgn_b & op_b[XLEN-1];
        b_zero = (op_b == '0);
        a_zero = (op_a == '0);
        ovf    = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (op_a == MIN_NEG) && (&op_b);
        spec_c = b_zero | a_zero | ovf;
        // funct3[1] separates remainder from quotient among the divide ops
        spec_val_c = '0;
        if (funct3[2] && b_zero) begin
            spec_val_c = funct3[1] ? op_a : '1;
        end else if (ovf) begin
            spec_val_c = funct3[1] ? '0 : MIN_NEG;
        end
    end

    muldiv_signfix #(.W(XLEN)) u_abs_a (.val_i(op_a), .neg_i(sa), .val_o(abs_a));
    muldiv_signfix #(.W(XLEN)) u_abs_b (.val_i(op_b), .neg_i(sb), .val_o(abs_b));

    // One iteration step: multiply adds then shifts right, divide shifts left then trial-subtracts
    always_comb begin
        mul_sum = {1'b0, hi_q} + ({1'b0, mag_q} & {(XLEN+1){lo_q[0]}});
        div_sh  = {hi_q, lo_q[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, mag_q});
        if (f3_q[2]) begin
            it_hi = div_ge ? (div_sh[XLEN-1:0] - mag_q) : div_sh[XLEN-1:0];
            it_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Result correction on the final iteration's values: pick half/quotient/remainder, fix sign
    always_comb begin
        if (f3_q[2]) begin
            raw_res = {{XLEN{1'b0}}, (f3_q[1] ? it_hi : it_lo)};
            res_neg = f3_q[1] ? negr_q : negq_q;
        end else begin
            raw_res = {it_hi, it_lo};
            res_neg = negq_q;
        end
    end

    muldiv_signfix #(.W(2*XLEN)) u_fix (.val_i(raw_res), .neg_i(res_neg), .val_o(fix_res));

    assign res_calc = (f3_q[2] || (f3_q == F3_MUL)) ? fix_res[XLEN-1:0] : fix_res[2*XLEN-1:XLEN];

    // Next-state, datapath load/iterate and handshake outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mag_d    = mag_q;
        spv_d    = spv_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        spec_d   = spec_q;
        result_d = result_q;
        ready    = (state_q == IDLE);
        stall    = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    stall   = 1'b1;
                    state_d = CALC;
                    cnt_d   = CW'(XLEN-1);
                    f3_d    = funct3;
                    hi_d    = '0;
                    lo_d    = funct3[2] ? abs_a : abs_b;
                    mag_d   = funct3[2] ? abs_b : abs_a;
                    negq_d  = sa ^ sb;
                    negr_d  = sa;
                    spec_d  = spec_c;
                    spv_d   = spec_val_c;
`ifdef MULDIV_FAST_EN
                    if (spec_c) begin
                        state_d  = DONE;
                        result_d = spec_val_c;
                    end
`endif
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = it_hi;
                    lo_d  = it_lo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        result_d = spec_q ? spv_q : res_calc;
                    end
                end
            end
            DONE: begin
                done    = !flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared by async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mag_q    <= '0;
            spv_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mag_q    <= mag_d;
            spv_q    <= spv_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            spec_q   <= spec_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule
